// File: rtl/conv_encoder.sv
// conv_encoder: IEEE 802.11a rate-1/2 K=7 convolutional encoder (g0=133, g1=171), WIDTH bits per beat.
// AXI-Stream in/out with a single output register stage; the 6-bit state clears at the end of each packet.
module conv_encoder #(
    parameter int WIDTH = 24
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [WIDTH-1:0]     s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [2*WIDTH-1:0]   m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast
);
    logic [5:0]           state;
    logic [WIDTH+5:0]     ext;
    logic [2*WIDTH-1:0]   coded;
    logic                 accept;

    assign s_axis_tready = !areset && (!m_axis_tvalid || m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    // ext[i+6] is b(i); ext[i+6-k] is b(i-k), reaching into the previous beat via state
    assign ext           = {s_axis_tdata, state};

    always_comb begin
        coded = '0;
        for (int i = 0; i < WIDTH; i++) begin
            coded[2*i]   = ext[i+6] ^ ext[i+4] ^ ext[i+3] ^ ext[i+1] ^ ext[i];
            coded[2*i+1] = ext[i+6] ^ ext[i+5] ^ ext[i+4] ^ ext[i+3] ^ ext[i];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (accept) begin
            state         <= s_axis_tlast ? 6'd0 : s_axis_tdata[WIDTH-1:WIDTH-6];
            m_axis_tdata  <= coded;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: directed vectors plus a randomized handshake run against a bit-serial encoder model.
module tb_conv_encoder;
    logic        aclk = 1'b0;
    logic        areset;
    logic [23:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [47:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    int          n_asserts = 0;
    int          n_fail = 0;
    logic [5:0]  sr = '0;
    logic [48:0] q[$];
    logic [48:0] exp_beat;
    logic [47:0] hold_data;

    conv_encoder #(.WIDTH(24)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [23:0] d, input logic last);
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        step();
        areset = 1'b0;
        sr = '0;
    endtask

    // Bit-serial reference: sr[k-1] holds b(n-k); returns {tlast, coded}
    function automatic logic [48:0] model(input logic [23:0] d, input logic last);
        logic [47:0] o;
        logic        b;
        o = '0;
        for (int n = 0; n < 24; n++) begin
            b = d[n];
            o[2*n]   = b ^ sr[1] ^ sr[2] ^ sr[4] ^ sr[5];
            o[2*n+1] = b ^ sr[0] ^ sr[1] ^ sr[2] ^ sr[5];
            sr = {sr[4:0], b};
        end
        if (last) sr = '0;
        return {last, o};
    endfunction

    initial begin
        bit in_fire, out_fire;
        int sent, cyc;
        areset = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
        step();
        step();
        chk("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("reset_tdata", 64'(m_axis_tdata), 64'd0);
        chk("reset_tlast", 64'(m_axis_tlast), 64'd0);
        chk("reset_tready", 64'(s_axis_tready), 64'd0);
        areset = 1'b0;
        #1;
        chk("tready_after_reset", 64'(s_axis_tready), 64'd1);

        send(24'h000000, 1'b0);
        chk("zero_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("zero_tdata", 64'(m_axis_tdata), 64'h0);
        step();
        chk("drop_tvalid", 64'(m_axis_tvalid), 64'd0);

        do_reset();
        send(24'h000001, 1'b0);
        chk("impulse", 64'(m_axis_tdata), 64'h0000000034FB);

        do_reset();
        send(24'h800000, 1'b0);
        chk("cross_first", 64'(m_axis_tdata), 64'hC00000000000);
        send(24'h000000, 1'b0);
        chk("cross_second", 64'(m_axis_tdata), 64'h000000000D3E);
        chk("cross_tvalid", 64'(m_axis_tvalid), 64'd1);
        do_reset();
        send(24'h800000, 1'b1);
        chk("last_first", 64'(m_axis_tdata), 64'hC00000000000);
        chk("last_tlast", 64'(m_axis_tlast), 64'd1);
        send(24'h000000, 1'b0);
        chk("last_second", 64'(m_axis_tdata), 64'h0);
        chk("last_tlast_clr", 64'(m_axis_tlast), 64'd0);
        step();
        chk("last_drop", 64'(m_axis_tvalid), 64'd0);

        do_reset();
        m_axis_tready = 1'b0;
        send(24'h000001, 1'b1);
        hold_data = m_axis_tdata;
        chk("bp_first", 64'(hold_data), 64'h0000000034FB);
        s_axis_tdata = 24'h123456; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_tready", 64'(s_axis_tready), 64'd0);
            chk("bp_tdata", 64'(m_axis_tdata), 64'h0000000034FB);
            chk("bp_tlast", 64'(m_axis_tlast), 64'd1);
            chk("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
            step();
        end
        m_axis_tready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            s_axis_tdata = (k == 0) ? 24'h123456 : 24'(k * 32'h0A5C31 + 32'h00F00F);
            s_axis_tlast = (k == 6);
            s_axis_tvalid = 1'b1;
            exp_beat = model(s_axis_tdata, s_axis_tlast);
            step();
            chk("stream_tvalid", 64'(m_axis_tvalid), 64'd1);
            chk("stream_tdata", 64'(m_axis_tdata), 64'(exp_beat[47:0]));
            chk("stream_tlast", 64'(m_axis_tlast), 64'(exp_beat[48]));
        end
        s_axis_tvalid = 1'b0;
        step();
        chk("stream_end", 64'(m_axis_tvalid), 64'd0);

        do_reset();
        m_axis_tready = 1'b0;
        send(24'h800000, 1'b0);
        chk("mid_held", 64'(m_axis_tvalid), 64'd1);
        areset = 1'b1;
        #1;
        chk("mid_rst_tready", 64'(s_axis_tready), 64'd0);
        step();
        chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_rst_tdata", 64'(m_axis_tdata), 64'd0);
        areset = 1'b0;
        m_axis_tready = 1'b1;
        send(24'h000000, 1'b0);
        chk("mid_after", 64'(m_axis_tdata), 64'h0);
        chk("mid_after_tvalid", 64'(m_axis_tvalid), 64'd1);

        do_reset();
        sent = 0;
        cyc = 0;
        while ((sent < 1000 || q.size() != 0 || m_axis_tvalid) && cyc < 20000) begin
            if (!s_axis_tvalid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                s_axis_tdata  = 24'($urandom);
                s_axis_tlast  = ($urandom_range(0, 7) == 0);
                s_axis_tvalid = 1'b1;
            end
            m_axis_tready = ($urandom_range(0, 3) != 0);
            #1;
            out_fire = m_axis_tvalid && m_axis_tready;
            in_fire  = s_axis_tvalid && s_axis_tready;
            if (out_fire) begin
                if (q.size() == 0) begin
                    chk("rand_extra_beat", 64'(m_axis_tdata), 64'hDEAD_0000_0000_0000);
                end else begin
                    exp_beat = q.pop_front();
                    chk("rand_tdata", 64'(m_axis_tdata), 64'(exp_beat[47:0]));
                    chk("rand_tlast", 64'(m_axis_tlast), 64'(exp_beat[48]));
                end
            end
            if (in_fire) begin
                q.push_back(model(s_axis_tdata, s_axis_tlast));
                sent++;
            end
            step();
            if (in_fire) s_axis_tvalid = 1'b0;
            cyc++;
        end
        chk("rand_timeout", 64'(cyc < 20000), 64'd1);
        chk("rand_sent", 64'(sent), 64'd1000);
        chk("rand_drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
